// File: rtl/spawn_pkg.sv
// Shared types and helpers for the ring-queue spawn schedulers.
`default_nettype none
package spawn_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_SPAWN   = 3'd2,
      S_UPDATE  = 3'd3,
      S_SETTLE  = 3'd4,
      S_REMOVE  = 3'd5,
      S_CRASHED = 3'd6
   } state_t;

   localparam int TYPE_NONE = 0;

   function automatic int unsigned mod_incr(input int unsigned v, input int unsigned m);
      return (v + 32'd1 >= m) ? 32'd0 : v + 32'd1;
   endfunction

   function automatic int unsigned mod_decr(input int unsigned v, input int unsigned m);
      return (v == 32'd0) ? m - 32'd1 : v - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_type_picker.sv
// Combinational type selection: rotate candidates from rng, gate on speed and duplicate history.
`default_nettype none
module spawn_type_picker #(
   parameter int TYPES     = 3,
   parameter int DUP_LIMIT = 2,
   parameter int TYPE_W    = 2,
   parameter int CNT_W     = 3
) (
   input  logic [15:0]                  rng,
   input  logic [14:0]                  speed,
   input  logic [TYPES*15-1:0]          min_speed,
   input  logic [DUP_LIMIT*TYPE_W-1:0]  history,
   input  logic [CNT_W-1:0]             count,
   output logic                         valid,
   output logic [TYPE_W-1:0]            pick_type
);

   logic [TYPES-1:0] accept;

   // History is newest-first; a repeat only blocks once the queue holds DUP_LIMIT entries.
   generate
      for (genvar t = 0; t < TYPES; t++) begin : g_accept
         logic [DUP_LIMIT-1:0] same;
         for (genvar k = 0; k < DUP_LIMIT; k++) begin : g_hist
            assign same[k] = (history[k*TYPE_W +: TYPE_W] == TYPE_W'(t + 1));
         end
         assign accept[t] = (speed >= min_speed[t*15 +: 15]) &&
                            !((count >= CNT_W'(DUP_LIMIT)) && (&same));
      end
   endgenerate

   always_comb begin
      valid     = 1'b0;
      pick_type = '0;
      for (int i = 0; i < TYPES; i++) begin
         for (int t = 0; t < TYPES; t++) begin
            if (!valid && accept[t] &&
                (((32'(rng) + 32'(i)) % 32'(TYPES)) == 32'(t))) begin
               valid     = 1'b1;
               pick_type = TYPE_W'(t + 1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spawn_scheduler.sv
// Ring-queue scheduler: spawns entities into slots, strobes updates, retires finished front slots.
`default_nettype none
module spawn_scheduler
   import spawn_pkg::*;
#(
   parameter int SLOTS         = 7,
   parameter int TYPES         = 3,
   parameter int DUP_LIMIT     = 2,
   parameter int PROB_BITS     = 0,
   parameter int SETTLE_CYCLES = 1,
   parameter int GAME_WIDTH    = 640,
   localparam int TYPE_W       = $clog2(TYPES + 1),
   localparam int PTR_W        = $clog2(SLOTS),
   localparam int CNT_W        = $clog2(SLOTS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     start,
   input  logic                     crash,
   input  logic                     enable,
   input  logic [15:0]              rng,
   input  logic [14:0]              speed,
   input  logic [TYPES*15-1:0]      min_speed,
   input  logic [SLOTS-1:0]         slot_visible,
   input  logic [SLOTS-1:0]         slot_remove,
   input  logic [SLOTS*11-1:0]      slot_x,
   input  logic [SLOTS*10-1:0]      slot_width,
   input  logic [SLOTS*11-1:0]      slot_gap,
   output logic [SLOTS-1:0]         slot_start,
   output logic [SLOTS*TYPE_W-1:0]  slot_type,
   output logic                     slot_update,
   output logic [PTR_W-1:0]         front,
   output logic [PTR_W-1:0]         back,
   output logic [CNT_W-1:0]         count,
   output logic                     done,
   output logic                     overflow
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t                      state, next_state;
   logic [TYPE_W-1:0]           type_q [SLOTS];
   logic [SET_W-1:0]            settle_cnt;
   logic [10:0]                 x_arr  [SLOTS];
   logic [9:0]                  w_arr  [SLOTS];
   logic [10:0]                 g_arr  [SLOTS];
   logic [PTR_W-1:0]            last;
   logic [PTR_W-1:0]            hist_idx;
   logic [DUP_LIMIT*TYPE_W-1:0] history;
   logic signed [12:0]          edge_sum;
   logic                        gap_ok, prob_ok, want, full, remove_ok, crash_hit, settle_last;
   logic                        pick_valid;
   logic [TYPE_W-1:0]           pick_type;

   generate
      for (genvar i = 0; i < SLOTS; i++) begin : g_slots
         assign x_arr[i]                       = slot_x[i*11 +: 11];
         assign w_arr[i]                       = slot_width[i*10 +: 10];
         assign g_arr[i]                       = slot_gap[i*11 +: 11];
         assign slot_type[i*TYPE_W +: TYPE_W]  = type_q[i];
      end
      if (PROB_BITS == 0) begin : g_no_prob
         assign prob_ok = 1'b1;
      end else begin : g_prob
         assign prob_ok = (rng[PROB_BITS-1:0] == '0);
      end
   endgenerate

   assign last = PTR_W'(mod_decr(32'(back), SLOTS));

   // Right edge of the newest entity; a new one may follow once it has scrolled inside the screen.
   assign edge_sum = $signed({{2{x_arr[last][10]}}, x_arr[last]})
                   + $signed({3'b000, w_arr[last]})
                   + $signed({2'b00, g_arr[last]});
   assign gap_ok      = (edge_sum < $signed(13'(GAME_WIDTH)));
   assign want        = enable && prob_ok && ((count == '0) || (slot_visible[last] && gap_ok));
   assign full        = (count == CNT_W'(SLOTS));
   assign remove_ok   = (count != '0) && slot_remove[front];
   assign crash_hit   = crash && (state != S_IDLE);
   assign settle_last = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

   always_comb begin
      history  = '0;
      hist_idx = back;
      for (int k = 0; k < DUP_LIMIT; k++) begin
         hist_idx                          = PTR_W'(mod_decr(32'(hist_idx), SLOTS));
         history[k*TYPE_W +: TYPE_W]       = type_q[hist_idx];
      end
   end

   spawn_type_picker #(
      .TYPES     (TYPES),
      .DUP_LIMIT (DUP_LIMIT),
      .TYPE_W    (TYPE_W),
      .CNT_W     (CNT_W)
   ) u_picker (
      .rng       (rng),
      .speed     (speed),
      .min_speed (min_speed),
      .history   (history),
      .count     (count),
      .valid     (pick_valid),
      .pick_type (pick_type)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      slot_update = (state == S_UPDATE);
      case (state)
         S_IDLE:    if (start) next_state = S_RUN;
         S_RUN:     if (tick)  next_state = S_SPAWN;
         S_SPAWN:   next_state = S_UPDATE;
         S_UPDATE:  next_state = (SETTLE_CYCLES == 0) ? S_REMOVE : S_SETTLE;
         S_SETTLE:  if (settle_last) next_state = S_REMOVE;
         S_REMOVE:  if (!remove_ok)  next_state = S_RUN;
         S_CRASHED: next_state = S_CRASHED;
         default:   next_state = S_IDLE;
      endcase
      if (crash_hit) next_state = S_CRASHED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         front      <= '0;
         back       <= '0;
         count      <= '0;
         slot_start <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         settle_cnt <= '0;
         for (int i = 0; i < SLOTS; i++) type_q[i] <= TYPE_W'(TYPE_NONE);
      end else begin
         done       <= 1'b0;
         settle_cnt <= (state == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
         if (!crash_hit) begin
            if (state == S_SPAWN && want) begin
               if (full) begin
                  overflow <= 1'b1;
               end else if (pick_valid) begin
                  slot_start[back] <= 1'b1;
                  type_q[back]     <= pick_type;
                  back             <= PTR_W'(mod_incr(32'(back), SLOTS));
                  count            <= count + CNT_W'(1);
               end
            end
            if (state == S_REMOVE) begin
               if (remove_ok) begin
                  slot_start[front] <= 1'b0;
                  type_q[front]     <= TYPE_W'(TYPE_NONE);
                  front             <= PTR_W'(mod_incr(32'(front), SLOTS));
                  count             <= count - CNT_W'(1);
               end else begin
                  done <= 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
